// File: rtl/fetch_unit.sv
// Program-fetch stage of the 4-bit CPU: program counter, phase flip-flop,
// fetch register and a run/single-step controller used for lab debugging.
//
// Ports:
//   clk      rising-edge clock for all state
//   reset    synchronous, active-low reset
//   run      level; 1 = free-running execution
//   step     one-cycle pulse; runs one instruction while stopped
//   incPC    from decoder; increment the program counter
//   loadPC   from decoder; load the program counter with ramAddr
//   romData  program ROM read data for romAddr
//   romAddr  ROM address (equals pc)
//   pc       current program counter
//   phase    0 = fetch, 1 = execute
//   instr    fetch register high nibble (opcode)
//   oprnd    fetch register low nibble (immediate / high address nibble)
//   ramAddr  {oprnd, romData}; RAM address and jump target
//   running  1 whenever state advances this cycle
module fetch_unit #(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            step,
    input  logic            incPC,
    input  logic            loadPC,
    input  logic [7:0]      romData,
    output logic [PC_W-1:0] romAddr,
    output logic [PC_W-1:0] pc,
    output logic            phase,
    output logic [3:0]      instr,
    output logic [3:0]      oprnd,
    output logic [PC_W-1:0] ramAddr,
    output logic            running
);

    typedef enum logic [1:0] {
        STOP   = 2'd0,
        RUN    = 2'd1,
        STEP_F = 2'd2,
        STEP_E = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] freg;
    logic       advance;

    assign advance = (state != STOP);
    assign running = advance;

    // Control FSM. RUN only drops back to STOP after the execute phase,
    // so a stop request always finishes the instruction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= STOP;
        end else begin
            unique case (state)
                STOP: begin
                    if (run)
                        state <= RUN;
                    else if (step)
                        state <= STEP_F;
                end
                RUN: begin
                    if (!run && phase)
                        state <= STOP;
                end
                STEP_F:  state <= STEP_E;
                STEP_E:  state <= STOP;
                default: state <= STOP;
            endcase
        end
    end

    // Datapath only moves on advance cycles; while stopped the decoder
    // strobes and romData (possibly unknown) cannot touch any register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc    <= RESET_PC;
            phase <= 1'b0;
            freg  <= 8'h00;
        end else if (advance) begin
            phase <= ~phase;
            if (!phase)
                freg <= romData;
            if (loadPC)
                pc <= ramAddr;
            else if (incPC)
                pc <= pc + PC_W'(1);
        end
    end

    assign romAddr = pc;
    assign instr   = freg[7:4];
    assign oprnd   = freg[3:0];
    assign ramAddr = PC_W'({freg[3:0], romData});

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, sequential run,
// jump, wrap/priority, stop and single-step, reset mid-instruction.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic        incPC;
    logic        loadPC;
    logic [7:0]  romData;
    logic [11:0] romAddr;
    logic [11:0] pc;
    logic        phase;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic [11:0] ramAddr;
    logic        running;

    logic [7:0]  rom [0:4095];

    // Decoder stand-in: strobes selected per phase.
    logic inc_p0, inc_p1, ld_p1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign romData = rom[romAddr];
    assign incPC   = phase ? inc_p1 : inc_p0;
    assign loadPC  = phase & ld_p1;

    fetch_unit dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .step    (step),
        .incPC   (incPC),
        .loadPC  (loadPC),
        .romData (romData),
        .romAddr (romAddr),
        .pc      (pc),
        .phase   (phase),
        .instr   (instr),
        .oprnd   (oprnd),
        .ramAddr (ramAddr),
        .running (running)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++)
            rom[i] = 8'h00;
        rom[12'h000] = 8'h4A;
        rom[12'h005] = 8'hC3;
        rom[12'h006] = 8'h7E;

        reset  = 1'b0;
        run    = 1'b1;
        step   = 1'b0;
        inc_p0 = 1'b0;
        inc_p1 = 1'b0;
        ld_p1  = 1'b0;

        // 1. reset held with run=1
        tick(2);
        chk("rst_pc", pc, 12'h000);
        chk("rst_phase", phase, 0);
        chk("rst_instr", instr, 0);
        chk("rst_oprnd", oprnd, 0);
        chk("rst_running", running, 0);
        reset = 1'b1;
        tick();
        chk("rel_running", running, 1);
        chk("rel_pc", pc, 12'h000);

        // 2. sequential run
        inc_p0 = 1'b1;
        tick();
        chk("seq_instr", instr, 4'h4);
        chk("seq_oprnd", oprnd, 4'hA);
        chk("seq_phase", phase, 1);
        chk("seq_pc1", pc, 12'h001);
        tick(5);
        chk("seq_pc6", pc, 12'h003);
        chk("seq_phase6", phase, 0);

        // 3. jump at 005
        tick(4);
        chk("jmp_pc5", pc, 12'h005);
        ld_p1 = 1'b1;
        tick();
        chk("jmp_pc6", pc, 12'h006);
        chk("jmp_ramaddr", ramAddr, 12'h37E);
        tick();
        chk("jmp_target", pc, 12'h37E);
        chk("jmp_phase", phase, 0);

        // 4. jump to FFF, wrap, then load/inc priority
        rom[12'h37E] = 8'h0F;
        rom[12'h37F] = 8'hFF;
        tick();
        chk("wr_ramaddr", ramAddr, 12'hFFF);
        tick();
        chk("wr_pcfff", pc, 12'hFFF);
        ld_p1 = 1'b0;
        rom[12'hFFF] = 8'h01;
        rom[12'h000] = 8'h23;
        tick();
        chk("wr_wrap", pc, 12'h000);
        inc_p1 = 1'b1;
        ld_p1  = 1'b1;
        chk("pri_ramaddr", ramAddr, 12'h123);
        tick();
        chk("pri_pc", pc, 12'h123);
        inc_p1 = 1'b0;
        ld_p1  = 1'b0;

        // 5a. stop request in phase 1 completes the instruction
        tick();
        chk("stp_pc", pc, 12'h124);
        chk("stp_ph1", phase, 1);
        run = 1'b0;
        tick();
        chk("stp_running", running, 0);
        chk("stp_phase", phase, 0);
        chk("stp_pc_a", pc, 12'h124);
        tick(3);
        chk("stp_frozen", pc, 12'h124);
        chk("stp_frozen_ph", phase, 0);

        // 5b. single step
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("sst_run_f", running, 1);
        chk("sst_pc_f", pc, 12'h124);
        tick();
        chk("sst_run_e", running, 1);
        chk("sst_pc_e", pc, 12'h125);
        tick();
        chk("sst_stop", running, 0);
        chk("sst_phase", phase, 0);
        tick(2);
        chk("sst_frozen", pc, 12'h125);

        // 5c. step held through STEP_E
        step = 1'b1;
        tick(3);
        step = 1'b0;
        chk("shl_stop", running, 0);
        chk("shl_pc", pc, 12'h126);
        tick(2);
        chk("shl_idle", running, 0);
        chk("shl_frozen", pc, 12'h126);

        // 6. reset during phase 1 with loadPC
        run = 1'b1;
        tick(2);
        chk("mid_ph1", phase, 1);
        chk("mid_pc", pc, 12'h127);
        ld_p1 = 1'b1;
        reset = 1'b0;
        tick();
        chk("mid_rst_pc", pc, 12'h000);
        chk("mid_rst_ph", phase, 0);
        chk("mid_rst_run", running, 0);
        chk("mid_rst_instr", instr, 0);
        ld_p1 = 1'b0;
        run   = 1'b0;
        reset = 1'b1;
        tick(2);
        chk("mid_idle", running, 0);
        chk("mid_idle_pc", pc, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
